// File: rtl/uart_tx.sv
// UART transmitter: start, 6..9 data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_BUFFER_EN to add a one-word holding register for back-to-back frames.
module uart_tx #(
    parameter int CE_PER_BIT = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ce,
    input  logic [1:0] i_length,
    input  logic       i_stop2,
    input  logic       i_parity,
    input  logic       i_odd,
    input  logic       i_wr,
    input  logic [8:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_done
);

    localparam int TW = (CE_PER_BIT > 1) ? $clog2(CE_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CE_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t      state_q;
    logic [TW-1:0] tick_q;
    logic [3:0]  bit_cnt_q;
    logic [8:0]  shift_q;
    logic        par_acc_q;
    logic        stop2_q;
    logic        parity_q;
    logic        odd_q;
    logic [1:0]  len_q;
    logic        tx_q;
    logic        busy_q;
    logic        done_q;

    logic        bit_end_d;
    logic        frame_end_d;
    logic        start_d;
    logic [8:0]  start_data_d;

`ifdef UART_TX_BUFFER_EN
    logic [8:0]  buf_q;
    logic        buf_valid_q;
`endif

    // A new frame starts from IDLE on a write, or (buffered) straight out of the last stop bit.
    always_comb begin
        bit_end_d    = i_ce && (tick_q == TICK_MAX);
        frame_end_d  = bit_end_d && ((state_q == STOP1 && !stop2_q) || state_q == STOP2);
        start_d      = 1'b0;
        start_data_d = i_data;
        if (state_q == IDLE) begin
            start_d = i_wr;
        end
`ifdef UART_TX_BUFFER_EN
        else if (frame_end_d) begin
            start_d      = buf_valid_q || i_wr;
            start_data_d = buf_valid_q ? buf_q : i_data;
        end
`endif
    end

`ifdef UART_TX_BUFFER_EN
    assign o_full = busy_q & buf_valid_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
        end else if (start_d && state_q != IDLE) begin
            buf_valid_q <= 1'b0;
        end else if (i_wr && !o_full && state_q != IDLE) begin
            buf_q       <= i_data;
            buf_valid_q <= 1'b1;
        end
    end
`else
    assign o_full = busy_q;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_acc_q <= 1'b0;
            stop2_q   <= 1'b0;
            parity_q  <= 1'b0;
            odd_q     <= 1'b0;
            len_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_d) begin
                state_q   <= START;
                tick_q    <= '0;
                shift_q   <= start_data_d;
                par_acc_q <= 1'b0;
                len_q     <= i_length;
                stop2_q   <= i_stop2;
                parity_q  <= i_parity;
                odd_q     <= i_odd;
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
                done_q    <= frame_end_d;
            end else if (state_q != IDLE && i_ce) begin
                tick_q <= bit_end_d ? '0 : tick_q + 1'b1;
                if (bit_end_d) begin
                    case (state_q)
                        START: begin
                            state_q   <= DATA;
                            tx_q      <= shift_q[0];
                            par_acc_q <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= 4'd5 + {2'b00, len_q};
                        end
                        DATA: begin
                            if (bit_cnt_q == 4'd0) begin
                                state_q <= parity_q ? PARITY : STOP1;
                                tx_q    <= parity_q ? (par_acc_q ^ odd_q) : 1'b1;
                            end else begin
                                tx_q      <= shift_q[0];
                                par_acc_q <= par_acc_q ^ shift_q[0];
                                shift_q   <= shift_q >> 1;
                                bit_cnt_q <= bit_cnt_q - 4'd1;
                            end
                        end
                        PARITY: begin
                            state_q <= STOP1;
                            tx_q    <= 1'b1;
                        end
                        STOP1, STOP2: begin
                            if (state_q == STOP1 && stop2_q) begin
                                state_q <= STOP2;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of known frames, buffer/drop and reset corner cases, random frames vs a line model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [1:0] len;
  logic       stop2;
  logic       par;
  logic       odd;
  logic       wr;
  logic [8:0] data;
  logic       tx, busy, full, done;

  int tests = 0;
  int fails = 0;

  uart_tx #(.CE_PER_BIT(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_length(len), .i_stop2(stop2),
    .i_parity(par), .i_odd(odd), .i_wr(wr), .i_data(data),
    .o_tx(tx), .o_busy(busy), .o_full(full), .o_done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  len;
    logic        stop2;
    logic        par;
    logic        odd;
    logic [8:0]  data;
    int          period;
    logic [12:0] bits;   // bit i = i-th bit on the line, start bit first
    int          nb;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference line model: the list of bit levels a frame puts on the wire.
  task automatic build_bits(input logic [1:0] l, input logic s2, input logic p, input logic o,
                            input logic [8:0] d, output logic [12:0] bits, output int nb);
    bit q[$];
    bit acc;
    acc = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < 6 + int'(l); i++) begin
      q.push_back(d[i]);
      acc ^= d[i];
    end
    if (p) q.push_back(acc ^ o);
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    nb = q.size();
    bits = '1;
    foreach (q[i]) bits[i] = q[i];
  endtask

  // Follows a frame whose start edge has just passed; bit index = ce pulses seen / 8.
  task automatic follow_frame(input logic [12:0] bits, input int nb, input int period,
                              input int inj_at, input logic [8:0] inj_data, input string name);
    int n, k, limit;
    bit pend;
    logic c;
    n = 0; k = 0; pend = 0;
    limit = 64 * nb + 100;
    while (n < 8 * nb && k < limit) begin
      @(negedge clk);
      k++;
      c = (period == 0) ? 1'($urandom_range(0, 1)) : 1'((k % period) == 0);
      ce = c;
      wr = 1'b0;
      if (k == inj_at) begin
        wr = 1'b1;
        data = inj_data;
      end
      if (k == inj_at + 5) begin
        wr = 1'b1;
        data = ~inj_data;
      end
      @(posedge clk);
      #1;
`ifdef UART_TX_BUFFER_EN
      if (k == inj_at) pend = 1;
`endif
      if (c) n++;
      if (n == 8 * nb) begin
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_end_tx"}, tx, pend ? 1'b0 : 1'b1);
        chk({name, "_end_busy"}, busy, pend ? 1'b1 : 1'b0);
        chk({name, "_end_full"}, full, 1'b0);
      end else begin
        chk({name, "_tx"}, tx, bits[n / 8]);
        chk({name, "_busy"}, busy, 1'b1);
        chk({name, "_nodone"}, done, 1'b0);
`ifdef UART_TX_BUFFER_EN
        chk({name, "_full"}, full, pend);
`else
        chk({name, "_full"}, full, 1'b1);
`endif
      end
    end
    if (n < 8 * nb) chk({name, "_timeout"}, n, 8 * nb);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] l, input logic s2, input logic p, input logic o,
                           input logic [8:0] d, input int period, input logic [12:0] bits,
                           input int nb, input string name);
    @(negedge clk);
    len = l; stop2 = s2; par = p; odd = o; data = d; wr = 1'b1; ce = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_start_tx"}, tx, 1'b0);
    chk({name, "_start_busy"}, busy, 1'b1);
    // Config and data changes after the write must not touch the frame in flight.
    len = 2'($urandom_range(0, 3)); stop2 = 1'($urandom_range(0, 1));
    par = 1'($urandom_range(0, 1)); odd = 1'($urandom_range(0, 1)); data = 9'($urandom);
    follow_frame(bits, nb, period, -1, 9'h0, name);
    ce = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_after_done"}, done, 1'b0);
    chk({name, "_after_tx"}, tx, 1'b1);
    chk({name, "_after_busy"}, busy, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [12:0] b, b2;
    int nb, nb2;
    logic [1:0] rl;
    logic rs, rp, ro;
    logic [8:0] rd;

    vecs[0] = '{2'd3, 1'b1, 1'b1, 1'b1, 9'h155, 1, 13'h1AAA, 13, "len9_odd_2stop"};
    vecs[1] = '{2'd0, 1'b0, 1'b1, 1'b0, 9'h007, 1, 13'h018E, 9,  "len6_even"};
    vecs[2] = '{2'd2, 1'b0, 1'b0, 1'b0, 9'h0A5, 4, 13'h034A, 10, "8n1_ce4"};
    vecs[3] = '{2'd3, 1'b0, 1'b0, 1'b0, 9'h0F0, 1, 13'h05E0, 11, "len9_nopar"};
    vecs[4] = '{2'd1, 1'b1, 1'b1, 1'b0, 9'h041, 1, 13'h0682, 11, "len7_even_2stop"};
    vecs[5] = '{2'd0, 1'b0, 1'b1, 1'b1, 9'h1C0, 1, 13'h0180, 9,  "len6_mask_odd"};

    rst = 1'b1; ce = 1'b1; len = 2'd0; stop2 = 1'b0; par = 1'b0; odd = 1'b0;
    wr = 1'b0; data = 9'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("idle_tx", tx, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_full", full, 1'b0);
      chk("idle_done", done, 1'b0);
    end

    foreach (vecs[i])
      run_frame(vecs[i].len, vecs[i].stop2, vecs[i].par, vecs[i].odd, vecs[i].data,
                vecs[i].period, vecs[i].bits, vecs[i].nb, vecs[i].name);

    // Write during a frame: held and sent with no gap when buffered, dropped otherwise.
    build_bits(2'd2, 1'b0, 1'b0, 1'b0, 9'h0C3, b, nb);
    build_bits(2'd2, 1'b0, 1'b0, 1'b0, 9'h05A, b2, nb2);
    @(negedge clk);
    len = 2'd2; stop2 = 1'b0; par = 1'b0; odd = 1'b0; data = 9'h0C3; wr = 1'b1; ce = 1'b1;
    @(posedge clk);
    #1;
    follow_frame(b, nb, 1, 20, 9'h05A, "buf_first");
`ifdef UART_TX_BUFFER_EN
    follow_frame(b2, nb2, 1, -1, 9'h0, "buf_second");
`endif
    ce = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("buf_idle_tx", tx, 1'b1);
      chk("buf_idle_busy", busy, 1'b0);
    end

    // Reset 30 clocks into a frame, then a clean frame.
    @(negedge clk);
    data = 9'h000; wr = 1'b1; ce = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    repeat (29) @(negedge clk);
    chk("pre_reset_tx", tx, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_full", full, 1'b0);
    chk("reset_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    build_bits(2'd2, 1'b0, 1'b1, 1'b0, 9'h03C, b, nb);
    run_frame(2'd2, 1'b0, 1'b1, 1'b0, 9'h03C, 1, b, nb, "post_reset");

    for (int t = 0; t < 25; t++) begin
      rl = 2'($urandom_range(0, 3)); rs = 1'($urandom_range(0, 1));
      rp = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1)); rd = 9'($urandom);
      build_bits(rl, rs, rp, ro, rd, b, nb);
      run_frame(rl, rs, rp, ro, rd, int'($urandom_range(0, 3)), b, nb, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
